// File: rtl/kyber_pkg.sv
// Shared types and constants for the Kyber coefficient datapath.
//   COEF_W : coefficient width in bits
//   NLANE  : coefficients packed into one datapath word
//   coef_t : one coefficient
//   word_t : one packed word, lane k = word[k*COEF_W +: COEF_W]
package kyber_pkg;
    localparam int COEF_W = 12;
    localparam int NLANE  = 4;

    typedef logic [COEF_W-1:0]       coef_t;
    typedef logic [NLANE*COEF_W-1:0] word_t;
endpackage

// File: rtl/piso4_if.sv
// Handshake bundle for the piso4 parallel-in serial-out converter.
//   in_valid/in_ready/din      : word-side valid/ready channel
//   out_valid/out_ready/dout   : coefficient-side valid/ready channel
//   out_last                   : last lane of a word (only with PISO4_LAST_EN)
// Modports: slave = the converter, master = whoever drives words in and
// consumes coefficients.
interface piso4_if
    import kyber_pkg::*;
#(
    parameter int IWID = COEF_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic [NLANE*IWID-1:0] din;
    logic                  out_valid;
    logic                  out_ready;
    logic [IWID-1:0]       dout;
`ifdef PISO4_LAST_EN
    logic                  out_last;
`endif

    modport slave (
        input  in_valid,
        input  din,
        input  out_ready,
`ifdef PISO4_LAST_EN
        output out_last,
`endif
        output in_ready,
        output out_valid,
        output dout
    );

    modport master (
        output in_valid,
        output din,
        output out_ready,
`ifdef PISO4_LAST_EN
        input  out_last,
`endif
        input  in_ready,
        input  out_valid,
        input  dout
    );
endinterface

// File: rtl/piso4_skid.sv
// One-entry shadow register with a valid flag.
//   clk, rst : clock, asynchronous active-low reset
//   load     : capture d and set vld
//   unload   : clear vld (ignored when load is also high)
//   d, q     : data in / held data
//   vld      : q holds a word
module piso4_skid #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         unload,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         vld
);
    logic [W-1:0] data_reg;
    logic         vld_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg <= '0;
            vld_reg  <= 1'b0;
        end else if (load) begin
            data_reg <= d;
            vld_reg  <= 1'b1;
        end else if (unload) begin
            vld_reg  <= 1'b0;
        end
    end

    assign q   = data_reg;
    assign vld = vld_reg;
endmodule

// File: rtl/piso4.sv
// Parallel-in serial-out converter: takes one word of four packed
// coefficients and emits them lane 0 first, one per accepted beat.
// A one-word shadow lets the next word be accepted while the current word
// shifts out, so a continuous stream runs at one coefficient per cycle.
//   clk : clock
//   rst : asynchronous active-low reset
//   bus : piso4_if slave (word in, coefficient out)
// Optional: define PISO4_LAST_EN to drive bus.out_last on the final lane.
module piso4
    import kyber_pkg::*;
#(
    parameter int IWID = COEF_W
) (
    input  logic     clk,
    input  logic     rst,
    piso4_if.slave   bus
);
    localparam int WW = NLANE * IWID;

    logic [WW-1:0]   main_reg,     main_next;
    logic            main_vld_reg, main_vld_next;
    logic [1:0]      cnt_reg,      cnt_next;

    logic [WW-1:0]   sh_q;
    logic            sh_vld;
    logic            sh_load;
    logic            sh_unload;

    logic            in_fire;
    logic            out_fire;
    logic            done;

    logic [IWID-1:0] lane [NLANE];

    // in_ready depends on registered state only, never on out_ready.
    assign bus.in_ready  = !sh_vld;
    assign bus.out_valid = main_vld_reg;

    assign in_fire  = bus.in_valid && !sh_vld;
    assign out_fire = main_vld_reg && bus.out_ready;
    assign done     = out_fire && (cnt_reg == 2'd3);

    // Lane mux: lane 0 is the least significant slice and goes out first.
    genvar gi;
    generate
        for (gi = 0; gi < NLANE; gi++) begin : g_lane
            assign lane[gi] = main_reg[gi*IWID +: IWID];
        end
    endgenerate

    assign bus.dout = lane[cnt_reg];

`ifdef PISO4_LAST_EN
    assign bus.out_last = main_vld_reg && (cnt_reg == 2'd3);
`endif

    // The shadow only fills while a word is mid-flight; when the final lane
    // leaves on the same edge, the incoming word goes straight to main.
    assign sh_load   = main_vld_reg && !done && in_fire;
    assign sh_unload = done && sh_vld;

    piso4_skid #(.W(WW)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (sh_load),
        .unload (sh_unload),
        .d      (bus.din),
        .q      (sh_q),
        .vld    (sh_vld)
    );

    always_comb begin
        main_next     = main_reg;
        main_vld_next = main_vld_reg;
        cnt_next      = cnt_reg;
        if (!main_vld_reg) begin
            if (in_fire) begin
                main_next     = bus.din;
                main_vld_next = 1'b1;
                cnt_next      = 2'd0;
            end
        end else if (done) begin
            cnt_next = 2'd0;
            if (sh_vld) begin
                main_next = sh_q;
            end else if (in_fire) begin
                main_next = bus.din;
            end else begin
                main_vld_next = 1'b0;
            end
        end else if (out_fire) begin
            cnt_next = cnt_reg + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_reg     <= '0;
            main_vld_reg <= 1'b0;
            cnt_reg      <= 2'd0;
        end else begin
            main_reg     <= main_next;
            main_vld_reg <= main_vld_next;
            cnt_reg      <= cnt_next;
        end
    end
endmodule

// File: tb/tb_piso4.sv
// Self-checking bench for piso4. The reference model is a queue of pending
// coefficients: an accepted word appends its four lanes (lane 0 first), an
// accepted beat pops the head. Expected flags follow from the queue size:
// out_valid = any pending, in_ready = fewer than two words held,
// out_last = exactly one lane of the current word left.
module tb_piso4;
    import kyber_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    piso4_if #(.IWID(COEF_W)) bus ();

    piso4 #(.IWID(COEF_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    vectors     = 0;
    int    miscompares = 0;
    coef_t exp_q[$];
    int    cyc         = 0;
    int    beat_no     = 0;
    logic  in_fire_s;
    logic  out_fire_s;
    int    last_beats[$];

    function automatic word_t rand_word();
        word_t w;
        w = word_t'({$urandom(), $urandom()});
        return w;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chkw(input string tag, input coef_t obs, input coef_t expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = exp_q.size();
        chk1("out_valid", bus.out_valid, sz > 0);
        chk1("in_ready", bus.in_ready, ((sz + 3) / 4) < 2);
        if (sz > 0) chkw("dout", bus.dout, exp_q[0]);
`ifdef PISO4_LAST_EN
        chk1("out_last", bus.out_last, (sz % 4) == 1);
`endif
    endtask

    // One clock: drive inputs, check at the falling edge, advance the model
    // at the rising edge. Entered and left at posedge+1.
    task automatic step(input logic iv, input word_t d, input logic ordy);
        int sz;
        bus.in_valid  = iv;
        bus.din       = d;
        bus.out_ready = ordy;
        @(negedge clk);
        check_outputs();
        sz         = exp_q.size();
        in_fire_s  = iv && (((sz + 3) / 4) < 2);
        out_fire_s = ordy && (sz > 0);
        if (out_fire_s) begin
            beat_no++;
            $display("beat %0d dout=%h", beat_no, bus.dout);
`ifdef PISO4_LAST_EN
            if (bus.out_last) last_beats.push_back(beat_no);
`endif
        end
        @(posedge clk);
        if (out_fire_s) void'(exp_q.pop_front());
        if (in_fire_s) begin
            $display("word accepted din=%h", d);
            for (int k = 0; k < NLANE; k++) exp_q.push_back(d[k*COEF_W +: COEF_W]);
        end
        cyc++;
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 60) begin
            step(1'b0, rand_word(), 1'b1);
            guard++;
        end
        chki("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        word_t w, a, b, c, x, y;
        int    accepted, first, last, beats, guard;

        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.din       = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        chkw("rst_dout", bus.dout, 12'h000);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        // Single word, lane 0 visible right after the accepting edge.
        w = {12'hD04, 12'hC03, 12'hB02, 12'hA01};
        step(1'b1, w, 1'b1);
        chkw("single_lane0", bus.dout, 12'hA01);
        repeat (4) step(1'b0, rand_word(), 1'b1);
        chk1("single_done_valid", bus.out_valid, 1'b0);

        // Streaming: 8 words, 32 beats with no bubble.
        accepted = 0; first = -1; last = -1; beats = 0; guard = 0;
        while ((accepted < 8 || exp_q.size() > 0) && guard < 100) begin
            step(accepted < 8, rand_word(), 1'b1);
            if (in_fire_s) accepted++;
            if (out_fire_s) begin
                if (first < 0) first = cyc;
                last = cyc;
                beats++;
            end
            guard++;
        end
        chki("stream_beats", beats, 32);
        chki("stream_span", last - first, 31);

        // Backpressure on lane 2; B goes to the shadow, C is refused.
        a = rand_word(); b = rand_word(); c = rand_word();
        step(1'b1, a, 1'b1);
        step(1'b0, rand_word(), 1'b1);
        step(1'b0, rand_word(), 1'b1);
        step(1'b1, b, 1'b0);
        repeat (4) step(1'b1, c, 1'b0);
        chkw("bp_hold_lane2", bus.dout, a[2*COEF_W +: COEF_W]);
        chk1("bp_in_ready", bus.in_ready, 1'b0);
        guard = 0;
        do begin
            step(1'b1, c, 1'b1);
            guard++;
        end while (!in_fire_s && guard < 20);
        chk1("bp_c_accepted", in_fire_s, 1'b1);
        drain();

        // Boundary: new word fires with the lane-3 beat, shadow empty.
        x = rand_word(); y = rand_word();
        step(1'b1, x, 1'b1);
        repeat (3) step(1'b0, rand_word(), 1'b1);
        step(1'b1, y, 1'b1);
        chk1("b2b_valid", bus.out_valid, 1'b1);
        chkw("b2b_lane0", bus.dout, y[COEF_W-1:0]);
        drain();

        // Boundary: shadow full when lane 3 leaves.
        x = rand_word(); y = rand_word();
        step(1'b1, x, 1'b0);
        step(1'b1, y, 1'b0);
        repeat (4) step(1'b0, rand_word(), 1'b1);
        chk1("shadow_in_ready", bus.in_ready, 1'b1);
        chkw("shadow_lane0", bus.dout, y[COEF_W-1:0]);
        drain();

`ifdef PISO4_LAST_EN
        // out_last over 3 words with random stalls.
        beat_no = 0;
        last_beats.delete();
        accepted = 0; guard = 0;
        while ((accepted < 3 || exp_q.size() > 0) && guard < 100) begin
            step(accepted < 3, rand_word(), $urandom_range(0, 2) != 0);
            if (in_fire_s) accepted++;
            guard++;
        end
        chki("last_count", last_beats.size(), 3);
        if (last_beats.size() == 3) begin
            chki("last_beat0", last_beats[0], 4);
            chki("last_beat1", last_beats[1], 8);
            chki("last_beat2", last_beats[2], 12);
        end
`endif

        // Random traffic against the queue model.
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 3) != 0);
        drain();

        // Reset after two lanes of a word have gone out.
        w = rand_word();
        step(1'b1, w, 1'b1);
        step(1'b0, rand_word(), 1'b1);
        step(1'b0, rand_word(), 1'b1);
        rst = 1'b0;
        #1;
        chk1("midrst_out_valid", bus.out_valid, 1'b0);
        chk1("midrst_in_ready", bus.in_ready, 1'b1);
        chkw("midrst_dout", bus.dout, 12'h000);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        w = 48'h004_003_002_001;
        step(1'b1, w, 1'b1);
        chkw("postrst_lane0", bus.dout, 12'h001);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/piso4.md
Name: piso4

Overview:
- Parallel-in serial-out converter for the Kyber coefficient datapath; the transmit-side counterpart of the 12-bit coefficient SIPO deserializer.
- Accepts one word of four packed coefficients and emits them one per cycle on a single IWID-bit lane, using a valid/ready handshake on both sides.
- A one-word shadow buffer allows the next word to be accepted while the current one is shifting out. Continuous streaming therefore runs at full rate (one coefficient per cycle).
- Sits between butterfly/NTT word outputs and serial coefficient consumers such as the compress and encode stages.

Parameters:
- IWID, 12, coefficient width in bits.
- NLANE, 4, coefficients per input word; fixed at 4, and the lane counter is 2 bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  din holds a valid word.
- in_ready  output  1  block can accept a word this cycle.
- din  input  NLANE*IWID  packed word; lane k = din[k*IWID +: IWID].
- out_valid  output  1  dout holds a valid coefficient.
- out_ready  input  1  downstream accepts dout this cycle.
- dout  output  IWID  serial coefficient.
- out_last  output  1  present only with PISO4_LAST_EN.

Behaviour:
- Reset:
  - rst is asynchronous and active-low.
  - While rst=0: main buffer and shadow buffer = 0, main_vld = 0, sh_vld = 0, lane counter cnt = 0.
  - Resulting outputs: out_valid=0, dout=0, in_ready=1.
  - Reset asserted mid-word discards the partial word and any shadow word. No resume.
- State: main register, main_vld, cnt[1:0]; shadow register, sh_vld.
  - Implied states: EMPTY (!main_vld), SHIFT (main_vld & !sh_vld), FULL (main_vld & sh_vld).
- Handshake signals:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Outputs:
  - in_ready = !sh_vld, registered-state only.
  - out_valid = main_vld.
  - dout = main lane cnt; lane 0 (din[IWID-1:0]) is emitted first, lane 3 last.
  - dout and out_valid hold stable while out_valid & !out_ready.
- Per-clock update (done = out_fire & cnt==3):
  - out_fire & cnt<3: cnt <= cnt+1.
  - done & sh_vld: main <= shadow, sh_vld <= 0, cnt <= 0, main_vld stays 1. A simultaneous in_fire cannot occur because in_ready=0.
  - done & !sh_vld & in_fire: main <= din, cnt <= 0, main_vld stays 1. This is back-to-back with no bubble.
  - done & !sh_vld & !in_fire: main_vld <= 0, cnt <= 0.
  - !main_vld & in_fire: main <= din, main_vld <= 1, cnt <= 0.
  - main_vld & !done & in_fire: shadow <= din, sh_vld <= 1.
- Latency: word accepted at edge N into EMPTY; lane 0 is on dout with out_valid=1 after edge N, and lane 3 appears after edge N+3 if out_ready stays high.
- Throughput: with in_valid and out_ready held high, out_valid stays 1 every cycle after the first word.
- Width: no arithmetic on data; coefficients pass bit-exact.
- Round trip: feeding dout into the SIPO deserializer reproduces the original lane order at its 4-lane output.

Optional Feature:
- Macro: PISO4_LAST_EN.
- Defined: out_last port exists and out_last = main_vld & (cnt==3). It resets to 0 and holds with dout under backpressure.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package kyber_pkg holds:
  - COEF_W = 12,
  - NLANE = 4,
  - a typedef coef_t of width COEF_W,
  - a typedef word_t of width NLANE*COEF_W.
- The shadow buffer is a natural sub-module, piso4_skid: a one-entry register with valid, load and unload.
- The lane counter and mux stay in piso4.

Test Plan:
- Reset: assert rst=0 mid-stream after 2 lanes sent -> out_valid=0, dout=0, in_ready=1 immediately. After release, a new word 0x004_003_002_001 emits 0x001, 0x002, 0x003, 0x004.
- Single word with out_ready=1: din lanes {0xD04, 0xC03, 0xB02, 0xA01} (lane3..lane0) -> dout sequence 0xA01, 0xB02, 0xC03, 0xD04 on four consecutive cycles, then out_valid=0.
- Streaming: 8 words, in_valid and out_ready held at 1 -> 32 consecutive valid beats with no bubble. in_ready deasserts whenever the shadow is full.
- Backpressure: out_ready=0 for 5 cycles on lane 2 -> dout holds the lane-2 value and cnt holds. A second word is accepted into the shadow, a third is refused (in_ready=0), and no data is lost or duplicated.
- Boundary: in_fire in the same cycle as the lane-3 out_fire with the shadow empty -> the next cycle shows the new lane 0 with no gap. With the shadow full, the shadow word emits next and in_ready rises.
- PISO4_LAST_EN: across 3 words, out_last=1 exactly on beats 4, 8 and 12, and it holds under out_ready=0.
